// File: rtl/tas_pkg.sv
// Shared types and constants for the time-aware shaper List Execute block:
// FSM state encoding, the all-open gate vector and the GCL entry layout.
package tas_pkg;

  localparam int TAS_NUM_QUEUES = 8;
  localparam int TAS_GCL_DEPTH  = 16;
  localparam int TAS_ADDR_W     = 4;
  localparam int TAS_INTERVAL_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_NEW_CYCLE    = 3'd1,
    ST_EXECUTE      = 3'd2,
    ST_DELAY        = 3'd3,
    ST_END_OF_CYCLE = 3'd4
  } tas_state_t;

  localparam logic [TAS_NUM_QUEUES-1:0] GATES_ALL_OPEN = {TAS_NUM_QUEUES{1'b1}};

  typedef struct packed {
    logic [TAS_NUM_QUEUES-1:0] gates;
    logic [TAS_INTERVAL_W-1:0] interval;
  } gcl_entry_t;

  // Lengths above the bank depth cannot be walked, so clamp them.
  function automatic logic [TAS_ADDR_W:0] sat_list_len(input logic [TAS_ADDR_W:0] len);
    logic [TAS_ADDR_W:0] depth;
    depth = (TAS_ADDR_W + 1)'(TAS_GCL_DEPTH);
    if (len > depth) begin
      return depth;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/tas_list_execute_sm_if.sv
// Software configuration bus of the List Execute block: admin GCL writes,
// list length and commit request, plus the commit-pending status.
interface tas_list_execute_sm_if
  import tas_pkg::*;
#(
  parameter int NUM_QUEUES = TAS_NUM_QUEUES,
  parameter int ADDR_W     = TAS_ADDR_W,
  parameter int INTERVAL_W = TAS_INTERVAL_W
);
  logic                  cfg_we;
  logic [ADDR_W-1:0]     cfg_addr;
  logic [NUM_QUEUES-1:0] cfg_gate_states;
  logic [INTERVAL_W-1:0] cfg_interval;
  logic [ADDR_W:0]       cfg_list_len;
  logic                  cfg_commit;
  logic                  cfg_pending;

  modport master (
    output cfg_we, cfg_addr, cfg_gate_states, cfg_interval, cfg_list_len, cfg_commit,
    input  cfg_pending
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_gate_states, cfg_interval, cfg_list_len, cfg_commit,
    output cfg_pending
  );
endinterface

// File: rtl/gcl_bank_regs.sv
// Double-buffered gate control list storage: software writes the admin bank,
// the FSM reads the oper bank, and a swap strobe exchanges their roles.
module gcl_bank_regs #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int ENTRY_W = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               swap,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [ENTRY_W-1:0] rdata
);
  logic [ENTRY_W-1:0] bank0 [DEPTH];
  logic [ENTRY_W-1:0] bank1 [DEPTH];
  logic               sel;

  // sel names the oper bank; the other one is admin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel <= 1'b0;
    end else if (swap) begin
      sel <= ~sel;
    end else begin
      sel <= sel;
    end
  end

  // A write coincident with a swap lands in the bank that becomes oper.
  always_ff @(posedge clk) begin
    if (we) begin
      if (sel) begin
        bank0[waddr] <= wdata;
      end else begin
        bank1[waddr] <= wdata;
      end
    end
  end

  assign rdata = sel ? bank1[raddr] : bank0[raddr];
endmodule

// File: rtl/tas_list_execute_sm.sv
// Time-aware shaper List Execute machine: walks the oper GCL once per
// cycle_start, holding each entry's gate vector until PTP time passes its exit.
module tas_list_execute_sm
  import tas_pkg::*;
#(
  parameter int NUM_QUEUES = TAS_NUM_QUEUES,
  parameter int GCL_DEPTH  = TAS_GCL_DEPTH,
  parameter int ADDR_W     = TAS_ADDR_W,
  parameter int INTERVAL_W = TAS_INTERVAL_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [63:0]           sync_time_ptp_ns_mini,
  input  logic                  cycle_start,
  tas_list_execute_sm_if.slave  cfg,
  output logic [NUM_QUEUES-1:0] gate_states,
  output logic [ADDR_W-1:0]     gcl_index,
  output logic                  list_active
);
  tas_state_t        state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   oper_len;
  logic [ADDR_W:0]   capt_len;
  logic              pending;
  logic [63:0]       exit_time;
  logic              swap;
  logic              last_entry;
  logic              zero_interval;
  gcl_entry_t        wr_entry;
  gcl_entry_t        oper_entry;

  assign swap          = cycle_start & pending;
  assign last_entry    = ({1'b0, idx} + {{ADDR_W{1'b0}}, 1'b1}) >= oper_len;
  assign zero_interval = (oper_entry.interval == {INTERVAL_W{1'b0}});
  assign cfg.cfg_pending = pending;

  always_comb begin
    wr_entry.gates    = cfg.cfg_gate_states;
    wr_entry.interval = cfg.cfg_interval;
  end

  gcl_bank_regs #(
    .DEPTH   (GCL_DEPTH),
    .ADDR_W  (ADDR_W),
    .ENTRY_W ($bits(gcl_entry_t))
  ) u_banks (
    .clk   (clk),
    .rst   (rst),
    .swap  (swap),
    .we    (cfg.cfg_we),
    .waddr (cfg.cfg_addr),
    .wdata (wr_entry),
    .raddr (idx),
    .rdata (oper_entry)
  );

  // Commit bookkeeping and the list walk; cycle_start pre-empts every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= {ADDR_W{1'b0}};
      oper_len    <= {(ADDR_W+1){1'b0}};
      capt_len    <= {(ADDR_W+1){1'b0}};
      pending     <= 1'b0;
      exit_time   <= 64'd0;
      gate_states <= GATES_ALL_OPEN;
      gcl_index   <= {ADDR_W{1'b0}};
      list_active <= 1'b0;
    end else begin
      // A fresh commit wins over the clear, so a commit on the swap clock stays pending.
      if (cfg.cfg_commit) begin
        pending  <= 1'b1;
        capt_len <= sat_list_len(cfg.cfg_list_len);
      end else if (swap) begin
        pending  <= 1'b0;
      end else begin
        pending  <= pending;
      end

      if (cycle_start) begin
        if (pending) begin
          oper_len <= capt_len;
        end else begin
          oper_len <= oper_len;
        end
        idx         <= {ADDR_W{1'b0}};
        state       <= ST_NEW_CYCLE;
        list_active <= 1'b0;
      end else begin
        case (state)
          ST_NEW_CYCLE: begin
            if (oper_len == {(ADDR_W+1){1'b0}}) begin
              gate_states <= GATES_ALL_OPEN;
              state       <= ST_END_OF_CYCLE;
              list_active <= 1'b0;
            end else begin
              state       <= ST_EXECUTE;
              list_active <= 1'b1;
            end
          end
          ST_EXECUTE: begin
            gate_states <= oper_entry.gates;
            gcl_index   <= idx;
            exit_time   <= sync_time_ptp_ns_mini + {{(64-INTERVAL_W){1'b0}}, oper_entry.interval};
            if (!zero_interval) begin
              state <= ST_DELAY;
            end else if (last_entry) begin
              state       <= ST_END_OF_CYCLE;
              list_active <= 1'b0;
            end else begin
              idx   <= idx + {{(ADDR_W-1){1'b0}}, 1'b1};
              state <= ST_EXECUTE;
            end
          end
          ST_DELAY: begin
            if (sync_time_ptp_ns_mini < exit_time) begin
              state <= ST_DELAY;
            end else if (last_entry) begin
              state       <= ST_END_OF_CYCLE;
              list_active <= 1'b0;
            end else begin
              idx   <= idx + {{(ADDR_W-1){1'b0}}, 1'b1};
              state <= ST_EXECUTE;
            end
          end
          ST_IDLE, ST_END_OF_CYCLE: begin
            state <= state;
          end
          default: begin
            state       <= ST_IDLE;
            list_active <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tas_list_execute_sm.sv
// Scoreboard bench: each cycle_start pushes the expected output changes
// (value and clock edge) of the walk; a monitor pops them as outputs change.
module tb_tas_list_execute_sm;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cycle_start = 1'b0;
  logic [63:0] ptp = 64'd1000;
  logic [7:0]  gate_states;
  logic [3:0]  gcl_index;
  logic        list_active;

  tas_list_execute_sm_if cfg_if ();

  tas_list_execute_sm dut (
    .clk                   (clk),
    .rst                   (rst),
    .sync_time_ptp_ns_mini (ptp),
    .cycle_start           (cycle_start),
    .cfg                   (cfg_if),
    .gate_states           (gate_states),
    .gcl_index             (gcl_index),
    .list_active           (list_active)
  );

  typedef struct {
    logic [12:0] obs;
    int          edge_no;
  } ev_t;

  ev_t         exp_q[$];
  logic [39:0] m_bank [2][16];
  bit          m_sel = 1'b0;
  bit          m_pending = 1'b0;
  int          m_capt = 0;
  int          m_oper_len = 0;
  logic [12:0] last_push = {1'b0, 4'd0, 8'hFF};
  int          lim = 0;
  int          due = 0;
  int          edge_cnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); edge_cnt = edge_cnt + 1; end
  initial forever begin @(negedge clk); ptp = ptp + 64'd1; end

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, act, exp, edge_cnt);
    end
  endtask

  function automatic int sat(input logic [4:0] l);
    return (l > 5'd16) ? 16 : int'(l);
  endfunction

  task automatic push_ev(input int e, input logic act, input logic [3:0] ix, input logic [7:0] g);
    ev_t ev;
    if (e < lim && {act, ix, g} !== last_push) begin
      ev.obs     = {act, ix, g};
      ev.edge_no = e;
      exp_q.push_back(ev);
      last_push  = ev.obs;
    end
  endtask

  task automatic cfg_write(input int addr, input logic [7:0] g, input logic [31:0] iv);
    @(negedge clk);
    cfg_if.cfg_we          = 1'b1;
    cfg_if.cfg_addr        = 4'(addr);
    cfg_if.cfg_gate_states = g;
    cfg_if.cfg_interval    = iv;
    m_bank[m_sel ? 0 : 1][addr] = {g, iv};
    @(negedge clk);
    cfg_if.cfg_we = 1'b0;
  endtask

  task automatic cfg_commit_len(input logic [4:0] len);
    @(negedge clk);
    cfg_if.cfg_commit   = 1'b1;
    cfg_if.cfg_list_len = len;
    m_pending = 1'b1;
    m_capt    = sat(len);
    @(negedge clk);
    cfg_if.cfg_commit = 1'b0;
    chk_eq("pending_set", cfg_if.cfg_pending, 1);
  endtask

  task automatic wait_due();
    while (edge_cnt + 1 < due) @(negedge clk);
  endtask

  // Pulse cycle_start (optionally with a commit) and push the walk's expected changes.
  task automatic launch(input int run, input bit with_commit, input logic [4:0] clen);
    int          c;
    int          t;
    logic [39:0] ent;
    int          iv;
    wait_due();
    cycle_start = 1'b1;
    if (with_commit) begin
      cfg_if.cfg_commit   = 1'b1;
      cfg_if.cfg_list_len = clen;
    end
    c   = edge_cnt + 1;
    lim = c + run;
    due = lim;
    if (m_pending) begin
      m_sel      = ~m_sel;
      m_oper_len = m_capt;
      m_pending  = 1'b0;
    end
    if (with_commit) begin
      m_pending = 1'b1;
      m_capt    = sat(clen);
    end
    push_ev(c, 1'b0, last_push[11:8], last_push[7:0]);
    if (m_oper_len == 0) begin
      push_ev(c + 1, 1'b0, last_push[11:8], 8'hFF);
    end else begin
      push_ev(c + 1, 1'b1, last_push[11:8], last_push[7:0]);
      t = c + 2;
      for (int i = 0; i < m_oper_len; i++) begin
        ent = m_bank[m_sel][i];
        iv  = int'(ent[31:0]);
        if (i == m_oper_len - 1 && iv == 0) push_ev(t, 1'b0, 4'(i), ent[39:32]);
        else push_ev(t, 1'b1, 4'(i), ent[39:32]);
        if (i == m_oper_len - 1 && iv != 0) push_ev(t + iv, 1'b0, 4'(i), ent[39:32]);
        t = t + iv + 1;
      end
    end
    @(negedge clk);
    cycle_start       = 1'b0;
    cfg_if.cfg_commit = 1'b0;
    chk_eq("pending_after_cs", cfg_if.cfg_pending, m_pending);
  endtask

  // Monitor: every change of {list_active, gcl_index, gate_states} must match the next expectation.
  initial begin
    logic [12:0] prev;
    logic [12:0] obs;
    ev_t         ev;
    prev = {1'b0, 4'd0, 8'hFF};
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = {1'b0, 4'd0, 8'hFF};
      end else begin
        obs = {list_active, gcl_index, gate_states};
        if (obs !== prev) begin
          if (exp_q.size() == 0) begin
            chk_eq("spurious_change", obs, prev);
          end else begin
            ev = exp_q.pop_front();
            chk_eq("out_value", obs, ev.obs);
            chk_eq("out_edge", edge_cnt, ev.edge_no);
          end
          prev = obs;
        end
      end
    end
  end

  initial begin
    cfg_if.cfg_we = 1'b0; cfg_if.cfg_addr = 4'd0; cfg_if.cfg_gate_states = 8'h00;
    cfg_if.cfg_interval = 32'd0; cfg_if.cfg_list_len = 5'd0; cfg_if.cfg_commit = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rst_gates", gate_states, 8'hFF);
    chk_eq("rst_index", gcl_index, 4'd0);
    chk_eq("rst_active", list_active, 1'b0);
    chk_eq("rst_pending", cfg_if.cfg_pending, 1'b0);
    rst = 1'b0;

    // Empty oper list: everything stays open.
    launch(1000, 1'b0, 5'd0);
    launch(1000, 1'b0, 5'd0);
    wait_due();
    chk_eq("empty_gates", gate_states, 8'hFF);
    chk_eq("empty_active", list_active, 1'b0);
    chk_eq("empty_index", gcl_index, 4'd0);

    // Three-entry list.
    cfg_write(0, 8'h01, 32'd100);
    cfg_write(1, 8'h02, 32'd200);
    cfg_write(2, 8'h80, 32'd300);
    cfg_commit_len(5'd3);
    launch(700, 1'b0, 5'd0);

    // Zero-length middle interval.
    cfg_write(0, 8'h01, 32'd50);
    cfg_write(1, 8'h04, 32'd0);
    cfg_write(2, 8'h10, 32'd50);
    cfg_commit_len(5'd3);
    launch(300, 1'b0, 5'd0);

    // Overrun: cycle_start 1000 ns into a 5000 ns entry.
    cfg_write(0, 8'h0F, 32'd5000);
    cfg_commit_len(5'd1);
    launch(1000, 1'b0, 5'd0);
    launch(5100, 1'b0, 5'd0);

    // Admin update while running, then commit coincident with cycle_start.
    launch(400, 1'b0, 5'd0);
    cfg_write(0, 8'h3C, 32'd40);
    cfg_commit_len(5'd1);
    chk_eq("oper_unchanged", gate_states, 8'h0F);
    launch(100, 1'b1, 5'd2);
    chk_eq("pending_kept", cfg_if.cfg_pending, 1'b1);

    // Asynchronous reset in the middle of a 5000 ns DELAY.
    launch(300, 1'b0, 5'd0);
    repeat (148) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_eq("arst_gates", gate_states, 8'hFF);
    chk_eq("arst_active", list_active, 1'b0);
    chk_eq("arst_index", gcl_index, 4'd0);
    chk_eq("arst_pending", cfg_if.cfg_pending, 1'b0);
    chk_eq("queue_before_rst", exp_q.size(), 0);
    exp_q.delete();
    m_sel = 1'b0; m_pending = 1'b0; m_capt = 0; m_oper_len = 0;
    last_push = {1'b0, 4'd0, 8'hFF};
    due = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    launch(50, 1'b0, 5'd0);

    // Full bank with an over-range length that must clamp to 16.
    for (int i = 0; i < 16; i++) cfg_write(i, 8'(i * 17 + 1), 32'(i % 3));
    chk_eq("post_rst_gates", gate_states, 8'hFF);
    chk_eq("post_rst_active", list_active, 1'b0);
    cfg_commit_len(5'd31);
    launch(200, 1'b0, 5'd0);
    wait_due();

    for (int k = 0; k < 300 && exp_q.size() > 0; k++) @(negedge clk);
    chk_eq("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
